stage_id_fwd: RTL
=================

STAGE_ID_FWD -- requirements
Module: stage_id_fwd

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and PC width.
REQ-002 SHALL have parameter NFWD, default 2, number of forwarding sources; index 0 is nearest stage, i.e. EX.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- if_valid  in  1  fetch offers instruction.
- if_pc  in  XLEN  fetched PC.
- if_inst  in  32  fetched instruction.
- id_ready  out  1  stage accepts fetch this cycle.
- ex_ready  in  1  EX accepts ID output this cycle.
- flush  in  1  kill held instruction.
- rs_addr, rt_addr  out  5 each  inst[25:21], inst[20:16] of held instruction, to register file.
- rf_rs, rf_rt  in  XLEN each  register-file read data.
- dec_srca  in  2  from external decoder: 0 RS, 1 SA zero-extended, else 0.
- dec_srcb  in  2  0 RT, 1 sign-extended imm16, 2 zero-extended imm16, else 0.
- dec_dst  in  2  0 RD, 1 RT, else 0.
- dec_br  in  5  branch type; bits[4:3] select target: 00 pc+4, 01 pc+4+(sext imm16<<2), 10 {pc[31:28],inst[25:0],00}, 11 pc+4; bit0=1 means BNE versus BEQ when bits[4:3]=01.
- dec_use_rs, dec_use_rt  in  1 each  instruction reads rs/rt.
- fwd_we  in  NFWD  source j will write fwd_dst[j].
- fwd_pend  in  NFWD  source j's value not yet available (load in flight).
- fwd_dst  in  5*NFWD  destination register per source.
- fwd_data  in  XLEN*NFWD  result per source.
- id_out_valid  out  1  valid instruction presented to EX.
- id_pc, id_inst  out  XLEN, 32  held PC and instruction.
- id_opa, id_opb, id_memdata  out  XLEN each  ALU operands and store data (forwarded RT).
- id_rfdst  out  5  destination register.
- id_brdst  out  XLEN  branch target.
- id_br_taken  out  1  early branch decision.
- stall_cnt  out  16  saturating hazard-stall cycle count.

Function
REQ-004 SHALL hold one instruction in a register with valid bit v; hazard is combinational.
REQ-005 SHALL detect a hazard when some j has fwd_we[j], fwd_pend[j], fwd_dst[j]!=0, and fwd_dst[j] equals rs with dec_use_rs or rt with dec_use_rt, and v=1.
REQ-006 SHALL drive id_out_valid = v & !hazard & !flush.
REQ-007 SHALL drive id_ready = !v | flush | (ex_ready & !hazard).
REQ-008 On each clk edge, SHALL apply the first matching case:
- flush: v<=0.
- id_ready & if_valid: capture pc/inst, v<=1.
- id_ready: v<=0.
- otherwise: hold.
REQ-009 SHALL forward rs: lowest j with fwd_we[j], !fwd_pend[j], fwd_dst[j]==rs, rs!=0 supplies fwd_data[j]; otherwise rf_rs. Same rule for rt.
REQ-010 SHALL never forward register 0; its operand value is the rf read value.
REQ-011 SHALL form id_opa, id_opb, id_rfdst and id_brdst per dec_* encodings using forwarded operands; id_memdata = forwarded rt; all additions modulo 2^XLEN.
REQ-012 SHALL increment stall_cnt once per cycle in which v & hazard & !flush, saturating at 16'hFFFF.
REQ-013 SHALL give zero-cycle ID latency: outputs reflect the held instruction combinationally.

Reset
REQ-014 On rst, SHALL set v=0, id_pc=0, id_inst=0 and stall_cnt=0 on the next clk edge; rst overrides flush and capture.
REQ-015 While v=0, SHALL produce outputs derived from inst=0 (nop) with id_out_valid=0.

Configuration
REQ-016 With STAGE_ID_BRANCH_EARLY_EN defined, SHALL set id_br_taken = id_out_valid & dec_br[4:3]==01 & (forwarded rs==rt xor dec_br[0]); branch dec_use_rs/rt operands count for hazards as in REQ-005.
REQ-017 Without STAGE_ID_BRANCH_EARLY_EN, SHALL tie id_br_taken to 0; id_brdst is still computed.

Verification
REQ-018 Reset then addi rt=5, imm 0xFFFF with dec_srcb=1 -> id_opb=0xFFFFFFFF, id_rfdst=5, id_out_valid=1.
REQ-019 rs=3, fwd0 (we, dst 3, data 0xA) and fwd1 (we, dst 3, data 0xB) -> id_opa=0xA; same with dst 0 -> id_opa=rf_rs.
REQ-020 fwd0 pend on dst 4, instruction uses rt=4, for 3 cycles -> id_out_valid=0, id_ready=0, pc held, stall_cnt=3; pend drop -> issue next cycle.
REQ-021 flush asserted while stalled with if_valid=1 -> v=0 next cycle, stall_cnt not incremented for that cycle, following fetch accepted.
REQ-022 pc=0x00400000, dec_br=01xxx, imm=0xFFFF -> id_brdst=0x00400000; with _EN and rs==rt, BEQ -> id_br_taken=1.
REQ-023 Force 65536 stall cycles -> stall_cnt stays 0xFFFF; rst -> 0.

Source files
------------

// File: rtl/stage_id_fwd.sv
// Decode/operand stage: holds one instruction, resolves RS/RT through forwarding sources, stalls on pending loads.
// Optional early branch resolution is enabled by defining STAGE_ID_BRANCH_EARLY_EN.
module stage_id_fwd #(
    parameter int XLEN = 32,
    parameter int NFWD = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_valid,
    input  logic [XLEN-1:0]      if_pc,
    input  logic [31:0]          if_inst,
    output logic                 id_ready,
    input  logic                 ex_ready,
    input  logic                 flush,
    output logic [4:0]           rs_addr,
    output logic [4:0]           rt_addr,
    input  logic [XLEN-1:0]      rf_rs,
    input  logic [XLEN-1:0]      rf_rt,
    input  logic [1:0]           dec_srca,
    input  logic [1:0]           dec_srcb,
    input  logic [1:0]           dec_dst,
    input  logic [4:0]           dec_br,
    input  logic                 dec_use_rs,
    input  logic                 dec_use_rt,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD-1:0]      fwd_pend,
    input  logic [5*NFWD-1:0]    fwd_dst,
    input  logic [XLEN*NFWD-1:0] fwd_data,
    output logic                 id_out_valid,
    output logic [XLEN-1:0]      id_pc,
    output logic [31:0]          id_inst,
    output logic [XLEN-1:0]      id_opa,
    output logic [XLEN-1:0]      id_opb,
    output logic [XLEN-1:0]      id_memdata,
    output logic [4:0]           id_rfdst,
    output logic [XLEN-1:0]      id_brdst,
    output logic                 id_br_taken,
    output logic [15:0]          stall_cnt
);

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic            vld_p0;
    logic [XLEN-1:0] pc_p0;
    logic [31:0]     inst_p0;
    logic [31:0]     inst;
    logic            hazard;
    logic            hazard_any;
    logic            rs_hit;
    logic            rt_hit;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] sext_imm;
    logic [XLEN-1:0] zext_imm;
    logic [XLEN-1:0] pc4;
    logic            unused_br;

    // An empty slot presents a nop so downstream decode sees inst = 0.
    assign inst    = vld_p0 ? inst_p0 : 32'd0;
    assign rs_addr = inst[25:21];
    assign rt_addr = inst[20:16];
    assign id_pc   = pc_p0;
    assign id_inst = inst;

    always_comb begin
        hazard_any = 1'b0;
        rs_hit     = 1'b0;
        rt_hit     = 1'b0;
        rs_val     = rf_rs;
        rt_val     = rf_rt;
        for (int j = 0; j < NFWD; j++) begin
            if (fwd_we[j] && fwd_pend[j] && fwd_dst[j*5 +: 5] != 5'd0 &&
                ((fwd_dst[j*5 +: 5] == rs_addr && dec_use_rs) ||
                 (fwd_dst[j*5 +: 5] == rt_addr && dec_use_rt)))
                hazard_any = 1'b1;
            // Lowest index is the youngest producer, so the first hit wins.
            if (!rs_hit && fwd_we[j] && !fwd_pend[j] && rs_addr != 5'd0 &&
                fwd_dst[j*5 +: 5] == rs_addr) begin
                rs_val = fwd_data[j*XLEN +: XLEN];
                rs_hit = 1'b1;
            end
            if (!rt_hit && fwd_we[j] && !fwd_pend[j] && rt_addr != 5'd0 &&
                fwd_dst[j*5 +: 5] == rt_addr) begin
                rt_val = fwd_data[j*XLEN +: XLEN];
                rt_hit = 1'b1;
            end
        end
    end

    assign hazard       = vld_p0 & hazard_any;
    assign id_out_valid = vld_p0 & ~hazard & ~flush;
    assign id_ready     = ~vld_p0 | flush | (ex_ready & ~hazard);

    assign sext_imm   = {{(XLEN-16){inst[15]}}, inst[15:0]};
    assign zext_imm   = {{(XLEN-16){1'b0}}, inst[15:0]};
    assign pc4        = pc_p0 + XLEN'(4);
    assign id_memdata = rt_val;

    always_comb begin
        case (dec_srca)
            2'd0:    id_opa = rs_val;
            2'd1:    id_opa = {{(XLEN-5){1'b0}}, inst[10:6]};
            default: id_opa = '0;
        endcase
        case (dec_srcb)
            2'd0:    id_opb = rt_val;
            2'd1:    id_opb = sext_imm;
            2'd2:    id_opb = zext_imm;
            default: id_opb = '0;
        endcase
        case (dec_dst)
            2'd0:    id_rfdst = inst[15:11];
            2'd1:    id_rfdst = inst[20:16];
            default: id_rfdst = 5'd0;
        endcase
        case (dec_br[4:3])
            2'b01:   id_brdst = pc4 + {sext_imm[XLEN-3:0], 2'b00};
            2'b10:   id_brdst = {pc_p0[XLEN-1:28], inst[25:0], 2'b00};
            default: id_brdst = pc4;
        endcase
    end

`ifdef STAGE_ID_BRANCH_EARLY_EN
    assign id_br_taken = id_out_valid & (dec_br[4:3] == 2'b01) & ((rs_val == rt_val) ^ dec_br[0]);
`else
    assign id_br_taken = 1'b0;
`endif
    assign unused_br = ^dec_br[2:0];

    // ID holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0    <= 1'b0;
            pc_p0     <= '0;
            inst_p0   <= 32'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (flush) begin
                vld_p0 <= 1'b0;
            end else if (id_ready && if_valid) begin
                pc_p0   <= if_pc;
                inst_p0 <= if_inst;
                vld_p0  <= 1'b1;
            end else if (id_ready) begin
                vld_p0 <= 1'b0;
            end
            if (hazard && !flush)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule
